uart_core_cfg: RTL and testbench
================================

// Module: uart_core_cfg
// PURPOSE
//  Parametrised full-duplex UART: one TX and one RX engine sharing a 16x baud tick generator.
//  Frame format is configurable: data bits, parity and stop bits.
//  Uses valid/ready handshakes on both the TX and RX byte interfaces.
//  RX has glitch-rejecting start detection, mid-bit sampling, framing/parity error flags and a sticky overrun flag.
//  Sits between the SoC byte-stream logic and the board pins; replaces the fixed 8N1 tx/rx pair.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock in Hz
//  BAUD_RATE    9600        line rate in bit/s
//  DATA_BITS    8           data bits per frame, legal 5..9
//  PARITY_MODE  0           0 = none, 1 = odd, 2 = even
//  STOP_BITS    1           1 or 2
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-high reset
//  tx_data       in   DATA_BITS  byte to send
//  tx_valid      in   1          tx_data is valid
//  tx_ready      out  1          TX engine idle; can accept a byte
//  tx            out  1          serial output, idles high
//  tx_busy       out  1          frame in progress (= ~tx_ready)
//  rx            in   1          serial input, asynchronous
//  rx_data       out  DATA_BITS  last received word
//  rx_valid      out  1          rx_data holds an unread word
//  rx_ready      in   1          consumer accepts rx_data
//  rx_frame_err  out  1          stop bit sampled low, for the word in rx_data
//  rx_parity_err out  1          parity mismatch, for the word in rx_data
//  rx_overrun    out  1          sticky: a frame completed while rx_valid was high
// BEHAVIOUR
//  Reset: tx=1, tx_ready=1, tx_busy=0, rx_data=0, rx_valid=0, all error flags 0, FSMs in IDLE, counters 0.
//  Tick: DIV = CLK_FREQ/(BAUD_RATE*16), minimum 1.
//   - Counter 0..DIV-1; tick is a 1-cycle pulse at wrap.
//   - Free-running; one bit = 16 ticks.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept on tx_valid&&tx_ready. Data is latched; tx_ready drops the next cycle.
//   - tx falls within 1 tick of acceptance.
//   - START drives 0, DATA drives LSB first (DATA_BITS bits), PARITY drives the odd/even bit over the data.
//   - STOP drives 1 for STOP_BITS*16 ticks.
//   - tx_ready rises in the cycle after the last stop tick. A back-to-back accept is allowed that cycle.
//   - tx_valid while busy is ignored; the data is not queued.
//  RX input: 2-FF synchroniser on rx; all logic uses the synchronised value.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: a low level on the synchronised rx enters START with the tick count cleared.
//   - START: sample at tick 7. If rx is high, treat it as a glitch and return to IDLE with no flags set.
//   - DATA/PARITY/STOP: sample every 16 ticks after the start-bit mid-point.
//   - Only the first stop bit is checked, even when STOP_BITS=2. The RX returns to IDLE right after it, so it can resync on the next start bit.
//  RX delivery: at the stop-bit sample the block loads rx_data, rx_frame_err and rx_parity_err, and sets rx_valid=1.
//   - Delivery happens even when there are errors.
//   - rx_valid stays high until a cycle with rx_valid&&rx_ready; it clears the following cycle.
//   - If a new frame completes while rx_valid=1: overwrite rx_data and the error flags, set rx_overrun.
//   - If a new frame completes in the same cycle as the handshake, it counts as a new word, not an overrun.
//   - rx_overrun clears only on reset.
//  Parity: odd means the XOR of data and the parity bit is 1; even means it is 0. With PARITY_MODE=0 there is no parity bit and rx_parity_err stays 0.
//  Reset mid-frame: both FSMs abort at once, tx returns high, and the partial frame is discarded.
//  Widths: data and shift registers are DATA_BITS wide; bit counter is 4 bits; tick/sample counter is 4 bits.
// CONFIGURATION
//  UART_LOOPBACK_EN defined:
//   - An extra input port loopback (1 bit) is added.
//   - When loopback=1, the RX synchroniser input is the internal tx and the external rx is ignored.
//   - The tx pin is held at 1 (idle) while in loopback.
//  UART_LOOPBACK_EN undefined: the port is absent and RX always samples the rx pin.
// TESTING
//  Bench parameters: CLK_FREQ=1_843_200, BAUD_RATE=115200, so DIV=1 and one bit = 16 clk.
//  1. 8N1: send tx_data=8'hA5 -> tx emits 0,1,0,1,0,0,1,0,1,1, each 16 clk; tx_ready returns after 160 clk.
//  2. 8E1 rx of 8'h3C with a correct parity bit (0) -> rx_valid=1, rx_data=8'h3C, both error flags 0. Repeat with parity=1 -> rx_parity_err=1.
//  3. Stop bit driven 0 on rx for byte 8'h55 -> rx_data=8'h55 and rx_frame_err=1; the next good frame is received correctly.
//  4. rx low pulse of 4 clk -> no rx_valid; the FSM returns to IDLE.
//  5. Two frames 8'h11 then 8'h22 with rx_ready=0 -> rx_data=8'h22, rx_overrun=1; one rx_ready cycle clears rx_valid, rx_overrun stays 1.
//  6. Assert rst in the middle of TX DATA -> tx=1 and tx_ready=1 immediately; a new byte 8'hFF sends cleanly. With loopback=1, 8'h5A comes back as rx_data=8'h5A.

Source files
------------

// File: rtl/uart_core_cfg.sv
// Full-duplex UART with configurable frame (data/parity/stop bits) and a shared 16x baud tick.
// Optional internal loopback (tx -> rx) is compiled in when UART_LOOPBACK_EN is defined.
module uart_core_cfg #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
`ifdef UART_LOOPBACK_EN
    output logic                 rx_overrun,
    input  logic                 loopback
`else
    output logic                 rx_overrun
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit PAR_EN  = (PARITY_MODE != 0);
    localparam bit PAR_ODD = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Parity bit that makes the frame satisfy the configured odd/even rule.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return PAR_ODD ? ~(^d) : (^d);
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    state_t               tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [3:0]           tx_bit_cnt;
    logic [3:0]           tx_tick_cnt;
    logic                 tx_line;
    logic                 tx_bit_end;

    // Each serial bit lasts 16 ticks; the 4-bit counter wraps at the bit boundary.
    assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= ST_IDLE;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_bit_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_line     <= 1'b1;
            tx_ready    <= 1'b1;
        end else begin
            if (tx_state != ST_IDLE && tick) begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
            case (tx_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift    <= tx_data;
                        tx_par      <= parity_of(tx_data);
                        tx_line     <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_line  <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == LAST_DATA) begin
                            tx_bit_cnt <= '0;
                            if (PAR_EN) begin
                                tx_line  <= tx_par;
                                tx_state <= ST_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= ST_STOP;
                            end
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                            tx_shift   <= tx_shift >> 1;
                            tx_line    <= tx_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_bit_end) begin
                        tx_line  <= 1'b1;
                        tx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == LAST_STOP) begin
                            tx_ready <= 1'b1;
                            tx_state <= ST_IDLE;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_busy = ~tx_ready;

    logic rx_src;

`ifdef UART_LOOPBACK_EN
    assign tx     = loopback ? 1'b1 : tx_line;
    assign rx_src = loopback ? tx_line : rx;
`else
    assign tx     = tx_line;
    assign rx_src = rx;
`endif

    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    state_t               rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic [3:0]           rx_bit_cnt;
    logic [3:0]           rx_tick_cnt;
    logic                 rx_par_err;
    logic                 rx_sample;

    assign rx_sample = tick && (rx_tick_cnt == 4'd15);

    // Samples land mid-bit: tick 7 of the start bit, then every 16 ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= ST_IDLE;
            rx_shift      <= '0;
            rx_bit_cnt    <= '0;
            rx_tick_cnt   <= '0;
            rx_par_err    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_state != ST_IDLE && tick) begin
                rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
            case (rx_state)
                ST_IDLE: begin
                    rx_tick_cnt <= '0;
                    rx_bit_cnt  <= '0;
                    rx_par_err  <= 1'b0;
                    if (!rx_sync) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick && rx_tick_cnt == 4'd7) begin
                        rx_tick_cnt <= '0;
                        rx_state    <= rx_sync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_sample) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == LAST_DATA) begin
                            rx_bit_cnt <= '0;
                            rx_state   <= PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (rx_sample) begin
                        rx_par_err <= (rx_sync != parity_of(rx_shift));
                        rx_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Only the first stop bit is checked so a following start bit can resync.
                    if (rx_sample) begin
                        rx_data       <= rx_shift;
                        rx_frame_err  <= ~rx_sync;
                        rx_parity_err <= rx_par_err;
                        rx_valid      <= 1'b1;
                        if (rx_valid && !rx_ready) begin
                            rx_overrun <= 1'b1;
                        end
                        rx_state <= ST_IDLE;
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench for uart_core_cfg: an 8N1 instance and an 8E1 instance at DIV=1 (16 clk per bit).
// Loopback checks are compiled only when UART_LOOPBACK_EN is defined.
module tb_uart_core_cfg;

    localparam int CLK_FREQ  = 1_843_200;
    localparam int BAUD_RATE = 115200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] tx_data_n, tx_data_e;
    logic       tx_valid_n, tx_valid_e;
    logic       tx_ready_n, tx_ready_e;
    logic       tx_n, tx_e;
    logic       tx_busy_n, tx_busy_e;
    logic       rx_n, rx_e;
    logic [7:0] rx_data_n, rx_data_e;
    logic       rx_valid_n, rx_valid_e;
    logic       rx_ready_n, rx_ready_e;
    logic       rx_frame_err_n, rx_frame_err_e;
    logic       rx_parity_err_n, rx_parity_err_e;
    logic       rx_overrun_n, rx_overrun_e;
`ifdef UART_LOOPBACK_EN
    logic       loopback_n, loopback_e;
`endif

    uart_core_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
    ) dut_n (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .tx(tx_n), .tx_busy(tx_busy_n), .rx(rx_n),
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
        .rx_frame_err(rx_frame_err_n), .rx_parity_err(rx_parity_err_n),
`ifdef UART_LOOPBACK_EN
        .rx_overrun(rx_overrun_n), .loopback(loopback_n)
`else
        .rx_overrun(rx_overrun_n)
`endif
    );

    uart_core_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
        .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)
    ) dut_e (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .tx(tx_e), .tx_busy(tx_busy_e), .rx(rx_e),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
        .rx_frame_err(rx_frame_err_e), .rx_parity_err(rx_parity_err_e),
`ifdef UART_LOOPBACK_EN
        .rx_overrun(rx_overrun_e), .loopback(loopback_e)
`else
        .rx_overrun(rx_overrun_e)
`endif
    );

    // Selects which instance the RX helpers observe: 0 = 8N1, 1 = 8E1.
    logic       sel;
    logic       m_valid, m_ferr, m_perr, m_overrun;
    logic [7:0] m_data;
    assign m_valid   = sel ? rx_valid_e      : rx_valid_n;
    assign m_data    = sel ? rx_data_e       : rx_data_n;
    assign m_ferr    = sel ? rx_frame_err_e  : rx_frame_err_n;
    assign m_perr    = sel ? rx_parity_err_e : rx_parity_err_n;
    assign m_overrun = sel ? rx_overrun_e    : rx_overrun_n;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       bad_par;
        logic       stop_val;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } rx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_exp_t;

    rx_vec_t vecs[8];
    rx_exp_t exp_q[$];
    logic    bit_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input logic s, input logic v);
        if (s) rx_e = v;
        else   rx_n = v;
    endtask

    task automatic drive_bit(input logic s, input logic v);
        set_line(s, v);
        repeat (16) @(negedge clk);
    endtask

    task automatic drive_rx(input logic s, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_val);
        drive_bit(s, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(s, d[i]);
        if (par_en) drive_bit(s, par_bit);
        drive_bit(s, stop_val);
        set_line(s, 1'b1);
    endtask

    task automatic wait_rx_valid(input string name, input int budget);
        int w;
        w = 0;
        while (!m_valid && w < budget) begin
            @(negedge clk);
            w++;
        end
        check_output(name, m_valid, 1);
    endtask

    task automatic rx_handshake(input string name);
        if (sel) rx_ready_e = 1'b1;
        else     rx_ready_n = 1'b1;
        @(negedge clk);
        rx_ready_e = 1'b0;
        rx_ready_n = 1'b0;
        check_output(name, m_valid, 0);
    endtask

    task automatic apply_stimulus(input int idx, input rx_vec_t v);
        rx_exp_t e;
        sel = v.sel;
        exp_q.push_back('{v.exp_data, v.exp_ferr, v.exp_perr});
        drive_rx(v.sel, v.data, v.sel, (^v.data) ^ v.bad_par, v.stop_val);
        wait_rx_valid($sformatf("vec%0d_valid", idx), 40);
        e = exp_q.pop_front();
        check_output($sformatf("vec%0d_data", idx), m_data, e.data);
        check_output($sformatf("vec%0d_ferr", idx), m_ferr, e.ferr);
        check_output($sformatf("vec%0d_perr", idx), m_perr, e.perr);
        check_output($sformatf("vec%0d_overrun", idx), m_overrun, 0);
        rx_handshake($sformatf("vec%0d_valid_clr", idx));
        repeat (32) @(negedge clk);
    endtask

    // Sends one byte on the 8N1 instance starting at a negedge with tx_ready high,
    // checks every bit at mid-bit and the exact cycle tx_ready returns.
    task automatic tx_frame_check(input logic [7:0] d, input logic poke);
        logic exp;
        tx_data_n  = d;
        tx_valid_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_n = 1'b0;
        check_output("tx_ready_drop", tx_ready_n, 0);
        check_output("tx_busy_set", tx_busy_n, 1);
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
        bit_q.push_back(1'b1);
        for (int n = 1; n <= 161; n++) begin
            if (n > 1) @(negedge clk);
            if (poke && n == 50) begin
                tx_valid_n = 1'b1;
                tx_data_n  = 8'h00;
            end
            if (poke && n == 51) tx_valid_n = 1'b0;
            if (n % 16 == 8) begin
                exp = bit_q.pop_front();
                check_output($sformatf("tx_%0h_bit%0d", d, n / 16), tx_n, exp);
            end
            if (n == 160) check_output("tx_ready_before_end", tx_ready_n, 0);
            if (n == 161) check_output("tx_ready_after_end", tx_ready_n, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tx_data_n = '0; tx_data_e = '0;
        tx_valid_n = 1'b0; tx_valid_e = 1'b0;
        rx_n = 1'b1; rx_e = 1'b1;
        rx_ready_n = 1'b0; rx_ready_e = 1'b0;
        sel = 1'b0;
`ifdef UART_LOOPBACK_EN
        loopback_n = 1'b0; loopback_e = 1'b0;
`endif

        vecs[0] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'hA7, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'hE7, 1'b0, 1'b0, 8'hE7, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_tx", tx_n, 1);
        check_output("reset_tx_ready", tx_ready_n, 1);
        check_output("reset_tx_busy", tx_busy_n, 0);
        check_output("reset_rx_valid", rx_valid_n, 0);
        check_output("reset_rx_data", rx_data_n, 0);
        check_output("reset_frame_err", rx_frame_err_n, 0);
        check_output("reset_parity_err", rx_parity_err_n, 0);
        check_output("reset_overrun", rx_overrun_n, 0);
        check_output("reset_tx_e", tx_e, 1);

        $display("[TB] TX 8N1 frames (second one back-to-back)");
        tx_frame_check(8'hA5, 1'b1);
        tx_frame_check(8'h0F, 1'b0);
        repeat (20) @(negedge clk);
        check_output("tx_idle_after", tx_n, 1);
        check_output("tx_ready_idle_after", tx_ready_n, 1);

        $display("[TB] RX glitch rejection");
        sel = 1'b0;
        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (40) @(negedge clk);
        check_output("glitch_no_valid", rx_valid_n, 0);

        $display("[TB] RX vector table");
        for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

        $display("[TB] RX overrun");
        sel = 1'b0;
        drive_rx(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_rx_valid("ovr_first_valid", 40);
        check_output("ovr_first_data", rx_data_n, 8'h11);
        check_output("ovr_first_flag", rx_overrun_n, 0);
        repeat (32) @(negedge clk);
        drive_rx(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_output("ovr_second_valid", rx_valid_n, 1);
        check_output("ovr_second_data", rx_data_n, 8'h22);
        check_output("ovr_second_flag", rx_overrun_n, 1);
        check_output("ovr_second_ferr", rx_frame_err_n, 0);
        rx_handshake("ovr_valid_clr");
        check_output("ovr_sticky", rx_overrun_n, 1);

        $display("[TB] Reset in the middle of a TX frame");
        tx_data_n  = 8'h00;
        tx_valid_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_n = 1'b0;
        repeat (40) @(negedge clk);
        check_output("midrst_tx_low", tx_n, 0);
        check_output("midrst_busy", tx_busy_n, 1);
        rst = 1'b1;
        #1;
        check_output("midrst_tx", tx_n, 1);
        check_output("midrst_tx_ready", tx_ready_n, 1);
        check_output("midrst_overrun", rx_overrun_n, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_frame_check(8'hFF, 1'b0);

`ifdef UART_LOOPBACK_EN
        $display("[TB] Loopback");
        sel = 1'b0;
        loopback_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_data_n  = 8'h5A;
        tx_valid_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_n = 1'b0;
        repeat (40) @(negedge clk);
        check_output("lb_pin_idle", tx_n, 1);
        wait_rx_valid("lb_valid", 200);
        check_output("lb_data", rx_data_n, 8'h5A);
        check_output("lb_ferr", rx_frame_err_n, 0);
        rx_handshake("lb_valid_clr");
        repeat (20) @(negedge clk);
        loopback_n = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
